// File: rtl/gpio_irq.sv
// Memory-mapped GPIO controller with input synchroniser, atomic set/clear/toggle,
// per-pin edge capture into sticky status bits and a masked, registered interrupt.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   address      CPU byte address, full 32-bit decode against BASE_ADDR
//   write_data   CPU write data
//   write_enable one register write per asserted cycle
//   read_data    combinational read data for the current address
//   gpio_pins    bidirectional pins, driven only where DIR=1
//   irq          level interrupt, registered
module gpio_irq #(
  parameter int unsigned N_PINS      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0010,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  input  logic              write_enable,
  output logic [31:0]       read_data,
  inout  wire  [N_PINS-1:0] gpio_pins,
  output logic              irq
);

  localparam logic [31:0] AddrData   = BASE_ADDR + 32'h00;
  localparam logic [31:0] AddrDir    = BASE_ADDR + 32'h04;
  localparam logic [31:0] AddrSet    = BASE_ADDR + 32'h08;
  localparam logic [31:0] AddrClr    = BASE_ADDR + 32'h0C;
  localparam logic [31:0] AddrToggle = BASE_ADDR + 32'h10;
  localparam logic [31:0] AddrMask   = BASE_ADDR + 32'h14;
  localparam logic [31:0] AddrRiseEn = BASE_ADDR + 32'h18;
  localparam logic [31:0] AddrFallEn = BASE_ADDR + 32'h1C;
  localparam logic [31:0] AddrStatus = BASE_ADDR + 32'h20;
  localparam logic [31:0] AddrDout   = BASE_ADDR + 32'h24;

  logic [N_PINS-1:0] dout_q,    dout_d;
  logic [N_PINS-1:0] dir_q,     dir_d;
  logic [N_PINS-1:0] mask_q,    mask_d;
  logic [N_PINS-1:0] rise_en_q, rise_en_d;
  logic [N_PINS-1:0] fall_en_q, fall_en_d;
  logic [N_PINS-1:0] status_q,  status_d;
  logic [N_PINS-1:0] prev_q,    prev_d;
  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] sync_d [SYNC_STAGES];
  logic              irq_q,     irq_d;

  logic [N_PINS-1:0] wd;
  logic [N_PINS-1:0] sync;
  logic [N_PINS-1:0] rise;
  logic [N_PINS-1:0] fall;
  logic [N_PINS-1:0] edge_hit;
  logic [N_PINS-1:0] rd_pins;
  logic              unused_wd;

  // Bits above N_PINS are dropped on write.
  assign wd        = write_data[N_PINS-1:0];
  assign unused_wd = ^write_data;

  // Pin drive: tristate per bit.
  for (genvar i = 0; i < N_PINS; i++) begin : g_pin_drv
    assign gpio_pins[i] = dir_q[i] ? dout_q[i] : 1'bz;
  end

  // Input synchroniser. Pins are sampled regardless of DIR so outputs loop back.
  always_comb begin
    sync_d[0] = gpio_pins;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign rise     = sync & ~prev_q;
  assign fall     = ~sync & prev_q;
  assign edge_hit = (rise & rise_en_q) | (fall & fall_en_q);

  // Register next-state.
  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    prev_d    = sync;
    status_d  = status_q;

    if (write_enable) begin
      if (address == AddrData)   dout_d    = wd;
      if (address == AddrDir)    dir_d     = wd;
      if (address == AddrSet)    dout_d    = dout_q | wd;
      if (address == AddrClr)    dout_d    = dout_q & ~wd;
      if (address == AddrToggle) dout_d    = dout_q ^ wd;
      if (address == AddrMask)   mask_d    = wd;
      if (address == AddrRiseEn) rise_en_d = wd;
      if (address == AddrFallEn) fall_en_d = wd;
      if (address == AddrStatus) status_d  = status_q & ~wd;
    end

    // A freshly detected edge overrides a simultaneous W1C.
    status_d = status_d | edge_hit;
  end

  // irq follows the stored status, so it rises one cycle after a status bit sets
  // and falls one cycle after the last masked bit clears.
  assign irq_d = |(status_q & mask_q);
  assign irq   = irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= '0;
      dir_q     <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  // Combinational read mux; unmapped and write-only offsets read zero.
  always_comb begin
    rd_pins = '0;
    if (address == AddrData)   rd_pins = sync;
    if (address == AddrDir)    rd_pins = dir_q;
    if (address == AddrMask)   rd_pins = mask_q;
    if (address == AddrRiseEn) rd_pins = rise_en_q;
    if (address == AddrFallEn) rd_pins = fall_en_q;
    if (address == AddrStatus) rd_pins = status_q;
    if (address == AddrDout)   rd_pins = dout_q;
  end

  always_comb begin
    read_data               = '0;
    read_data[N_PINS-1:0]   = rd_pins;
  end

endmodule
